// File: rtl/register_file.sv
// Register bank: 2 registered read ports, 1 byte-strobed write port with forwarding,
//   and a sequential clear engine.
// Latency: reads take 1 cycle. A write is visible to a same-edge read through forwarding.
// Backpressure: none. While busy=1, writes are dropped and reads return 0.
//
// Ports:
//   clk, rst                 clock (rising edge), async active-high reset
//   we/waddr/wdata/wstrb     write request with byte-lane strobes
//   re_x/raddr_x/rdata_x     read port x (A, B); rdata_x holds its value when re_x=0
//   clear_req, busy          start a bank clear; busy is high while the clear runs
module register_file #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int ADDR_W   = $clog2(DEPTH),
    parameter int ZERO_REG = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 we,
    input  logic [ADDR_W-1:0]    waddr,
    input  logic [WIDTH-1:0]     wdata,
    input  logic [WIDTH/8-1:0]   wstrb,
    input  logic                 re_a,
    input  logic [ADDR_W-1:0]    raddr_a,
    output logic [WIDTH-1:0]     rdata_a,
    input  logic                 re_b,
    input  logic [ADDR_W-1:0]    raddr_b,
    output logic [WIDTH-1:0]     rdata_b,
    input  logic                 clear_req,
    output logic                 busy
);

    localparam int NB    = WIDTH / 8;
    // The storage index only needs to cover DEPTH entries. ADDR_W may be wider, so
    // out-of-range addresses can be detected and dropped.
    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]    mem_q [DEPTH];
    logic [WIDTH-1:0]    mem_d [DEPTH];
    logic [WIDTH-1:0]    rdata_a_q, rdata_a_d;
    logic [WIDTH-1:0]    rdata_b_q, rdata_b_d;

    logic                wr_ok;
    logic [WIDTH-1:0]    wr_old;
    logic [WIDTH-1:0]    wr_merged;

    // An address is writable or readable only if it is in range.
    // When ZERO_REG is set, entry 0 is also excluded.
    function automatic logic addr_live(input logic [ADDR_W-1:0] a);
        return (32'(a) < DEPTH) && !((ZERO_REG != 0) && (a == '0));
    endfunction

    // Write path. The merged word feeds both the array and the forwarding muxes.
    always_comb begin
        wr_ok     = we && (state_q == IDLE) && addr_live(waddr);
        wr_old    = mem_q[waddr[IDX_W-1:0]];
        wr_merged = wr_old;
        for (int i = 0; i < NB; i++) begin
            if (wstrb[i]) begin
                wr_merged[8*i +: 8] = wdata[8*i +: 8];
            end
        end
    end

    // Read value as seen on this edge. A write landing on the same entry is
    // forwarded, so the read returns post-write data. The whole bank reads as
    // zero while it is being cleared.
    function automatic logic [WIDTH-1:0] read_word(input logic [ADDR_W-1:0] ra);
        logic [WIDTH-1:0] v;
        v = '0;
        if (state_q == IDLE && addr_live(ra)) begin
            if (wr_ok && (ra == waddr)) begin
                v = wr_merged;
            end else begin
                v = mem_q[ra[IDX_W-1:0]];
            end
        end
        return v;
    endfunction

    always_comb begin
        rdata_a_d = rdata_a_q;
        rdata_b_d = rdata_b_q;
        if (re_a) begin
            rdata_a_d = read_word(raddr_a);
        end
        if (re_b) begin
            rdata_b_d = read_word(raddr_b);
        end
    end

    // Array update and clear FSM. In CLEAR, writes are blocked by wr_ok, so the
    // only array change is the entry under the counter.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end

        if (wr_ok) begin
            mem_d[waddr[IDX_W-1:0]] = wr_merged;
        end

        case (state_q)
            IDLE: begin
                if (clear_req) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            CLEAR: begin
                mem_d[cnt_q[IDX_W-1:0]] = '0;
                if (32'(cnt_q) == DEPTH - 1) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + ADDR_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rdata_a_q <= '0;
            rdata_b_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rdata_a_q <= rdata_a_d;
            rdata_b_q <= rdata_b_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign rdata_a = rdata_a_q;
    assign rdata_b = rdata_b_q;
    assign busy    = (state_q == CLEAR);

endmodule

// File: tb/tb_register_file.sv
// Testbench for register_file: directed scenarios followed by randomized traffic,
//   all checked against a behavioural model of the bank.
// Latency: reads are checked 1 cycle after issue. Backpressure: the bench watches busy.
module tb_register_file;

    localparam int WIDTH  = 32;
    localparam int DEPTH  = 32;
    localparam int ADDR_W = 6;   // wide enough to express out-of-range addresses like 40

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              we = 1'b0;
    logic [ADDR_W-1:0] waddr = '0;
    logic [WIDTH-1:0]  wdata = '0;
    logic [3:0]        wstrb = '0;
    logic              re_a = 1'b0;
    logic [ADDR_W-1:0] raddr_a = '0;
    logic [WIDTH-1:0]  rdata_a;
    logic              re_b = 1'b0;
    logic [ADDR_W-1:0] raddr_b = '0;
    logic [WIDTH-1:0]  rdata_b;
    logic              clear_req = 1'b0;
    logic              busy;

    int errors = 0;
    int checks = 0;

    // Behavioural model: the array contents, the held read values, and the
    // number of clear cycles still to run.
    logic [31:0] m_mem [DEPTH];
    logic [31:0] m_ra, m_rb;
    int          m_clear_left;

    register_file #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W), .ZERO_REG(1)) dut (
        .clk(clk), .rst(rst),
        .we(we), .waddr(waddr), .wdata(wdata), .wstrb(wstrb),
        .re_a(re_a), .raddr_a(raddr_a), .rdata_a(rdata_a),
        .re_b(re_b), .raddr_b(raddr_b), .rdata_b(rdata_b),
        .clear_req(clear_req), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] m_merge(input logic [31:0] old, input logic [31:0] nw,
                                            input logic [3:0] strb);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) r[8*b +: 8] = nw[8*b +: 8];
        end
        return r;
    endfunction

    function automatic bit m_write_takes();
        return we && (m_clear_left == 0) && (int'(waddr) < DEPTH) && (waddr != 0);
    endfunction

    function automatic logic [31:0] m_read(input logic [ADDR_W-1:0] a);
        if (m_clear_left > 0) return 32'h0;
        if (int'(a) >= DEPTH || a == 0) return 32'h0;
        if (m_write_takes() && waddr == a) return m_merge(m_mem[int'(a)], wdata, wstrb);
        return m_mem[int'(a)];
    endfunction

    task automatic m_reset();
        for (int i = 0; i < DEPTH; i++) m_mem[i] = 32'h0;
        m_ra = 32'h0;
        m_rb = 32'h0;
        m_clear_left = 0;
    endtask

    // Advance one clock edge. The model is updated from the inputs driven before
    // the edge, then all outputs are compared 1 time unit after the edge.
    task automatic cycle(input string tag);
        logic [31:0] ea, eb;
        ea = re_a ? m_read(raddr_a) : m_ra;
        eb = re_b ? m_read(raddr_b) : m_rb;
        if (m_write_takes()) m_mem[int'(waddr)] = m_merge(m_mem[int'(waddr)], wdata, wstrb);
        if (m_clear_left > 0) begin
            m_mem[DEPTH - m_clear_left] = 32'h0;
            m_clear_left--;
        end else if (clear_req) begin
            m_clear_left = DEPTH;
        end
        @(posedge clk);
        #1;
        m_ra = ea;
        m_rb = eb;
        check({tag, "/rdata_a"}, rdata_a, ea);
        check({tag, "/rdata_b"}, rdata_b, eb);
        check({tag, "/busy"}, {31'b0, busy}, {31'b0, (m_clear_left > 0)});
    endtask

    task automatic idle_inputs();
        we = 1'b0; re_a = 1'b0; re_b = 1'b0; clear_req = 1'b0; wstrb = 4'h0;
    endtask

    task automatic wr(input int a, input logic [31:0] d, input logic [3:0] s);
        idle_inputs();
        we = 1'b1; waddr = ADDR_W'(a); wdata = d; wstrb = s;
        cycle("write");
        we = 1'b0;
    endtask

    task automatic rd_a(input int a, input logic [31:0] exp, input string tag);
        idle_inputs();
        re_a = 1'b1; raddr_a = ADDR_W'(a);
        cycle(tag);
        check({tag, "/direct"}, rdata_a, exp);
        re_a = 1'b0;
    endtask

    initial begin
        int bc;
        m_reset();

        // 1. Reset state and first read after release.
        #1 rst = 1'b1;
        #2;
        check("reset/rdata_a", rdata_a, 32'h0);
        check("reset/rdata_b", rdata_b, 32'h0);
        check("reset/busy", {31'b0, busy}, 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;
        rd_a(5, 32'h0, "t1_read5");

        // 2. Full write, then a partial strobe write.
        wr(3, 32'hDEADBEEF, 4'hF);
        rd_a(3, 32'hDEADBEEF, "t2_full");
        wr(3, 32'h00001234, 4'h3);
        rd_a(3, 32'hDEAD1234, "t2_strb");
        wr(3, 32'hFFFFFFFF, 4'h0);
        rd_a(3, 32'hDEAD1234, "t2_nostrb");

        // 3. Forwarding to both ports on the same edge.
        idle_inputs();
        we = 1'b1; waddr = 7; wdata = 32'hA5A5A5A5; wstrb = 4'hF;
        re_a = 1'b1; raddr_a = 7; re_b = 1'b1; raddr_b = 7;
        cycle("t3_fwd");
        check("t3_fwd_a", rdata_a, 32'hA5A5A5A5);
        check("t3_fwd_b", rdata_b, 32'hA5A5A5A5);
        // Forwarding of a partial write merges in the old bytes.
        we = 1'b1; waddr = 7; wdata = 32'h0000_00FF; wstrb = 4'h1;
        re_a = 1'b1; raddr_a = 7; re_b = 1'b0;
        cycle("t3_fwd_part");
        check("t3_fwd_part_a", rdata_a, 32'hA5A5A5FF);
        check("t3_hold_b", rdata_b, 32'hA5A5A5A5);

        // 4. Entry 0 is hardwired to zero; out-of-range writes are dropped.
        wr(8, 32'h0808_0808, 4'hF);
        wr(0, 32'hFFFFFFFF, 4'hF);
        rd_a(0, 32'h0, "t4_zero");
        wr(40, 32'h4040_4040, 4'hF);
        for (int i = 0; i < DEPTH; i++) rd_a(i, m_mem[i], "t4_scan");
        rd_a(8, 32'h0808_0808, "t4_alias8");
        rd_a(40, 32'h0, "t4_oor_read");

        // 5. Fill the bank, clear it, and try a write while busy.
        for (int i = 1; i < DEPTH; i++) wr(i, 32'h1000_0000 + i, 4'hF);
        idle_inputs();
        clear_req = 1'b1;
        cycle("t5_start");
        clear_req = 1'b0;
        bc = 0;
        while (busy && bc < 100) begin
            idle_inputs();
            if (bc == 20) begin
                we = 1'b1; waddr = 3; wdata = 32'hBAD0BAD0; wstrb = 4'hF;
            end
            cycle("t5_busy");
            bc++;
        end
        check("t5_busy_len", bc, 32);
        for (int i = 0; i < DEPTH; i++) rd_a(i, 32'h0, "t5_cleared");

        // 6. Asynchronous reset in the middle of a clear.
        for (int i = 1; i < 12; i++) wr(i, 32'h6000_0000 + i, 4'hF);
        rd_a(4, 32'h6000_0004, "t6_pre");
        idle_inputs();
        clear_req = 1'b1;
        cycle("t6_start");
        clear_req = 1'b0;
        for (int i = 0; i < 10; i++) cycle("t6_run");
        #2 rst = 1'b1;
        #1;
        m_reset();
        check("t6_async_busy", {31'b0, busy}, 32'h0);
        check("t6_async_rdata_a", rdata_a, 32'h0);
        check("t6_async_rdata_b", rdata_b, 32'h0);
        #2 rst = 1'b0;
        wr(2, 32'h2222_2222, 4'hF);
        rd_a(2, 32'h2222_2222, "t6_post_write");
        rd_a(11, 32'h0, "t6_zeroed");

        // Randomized traffic against the model.
        for (int n = 0; n < 600; n++) begin
            we        = ($urandom_range(0, 3) != 0);
            waddr     = ADDR_W'($urandom_range(0, 40));
            wdata     = $urandom;
            wstrb     = 4'($urandom_range(0, 15));
            re_a      = $urandom_range(0, 1) != 0;
            raddr_a   = ADDR_W'($urandom_range(0, 36));
            re_b      = $urandom_range(0, 1) != 0;
            raddr_b   = ($urandom_range(0, 3) == 0) ? waddr : ADDR_W'($urandom_range(0, 36));
            clear_req = ($urandom_range(0, 59) == 0);
            cycle("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
